song_sequencer: RTL
===================

// Module: song_sequencer
// PURPOSE
//   Player-side counterpart of the music controller. Consumes play / reset_player / song[1:0],
//   walks the selected song's note list in the song ROM and hands each note to the note player.
//   Reports song_done to the controller when the song ends.
//   Sits between the controller, the song ROM (registered read) and the note player.
// PARAMETERS
//   SONG_W   2  song select width (4 songs)
//   IDX_W    5  note index width (2**IDX_W notes per song)
//   NOTE_W   6  note code width
//   DUR_W    6  duration width; duration==0 in ROM is the end-of-song marker
//   ROM_LAT  1  ROM read latency in cycles, legal values 1..2
// PORTS
//   clk           in   1               system clock
//   reset_n       in   1               asynchronous reset, active-low
//   play          in   1               level; 1 = advance, 0 = pause
//   reset_player  in   1               synchronous restart of the current song, pulse
//   song          in   SONG_W          song select, used live in rom_addr
//   note_done     in   1               one-cycle pulse from note player: current note finished
//   rom_addr      out  SONG_W+IDX_W    {song, idx}, combinational from live song and registered idx
//   rom_note      in   NOTE_W          ROM data, valid ROM_LAT cycles after rom_addr is stable
//   rom_dur       in   DUR_W           ROM data, same timing as rom_note
//   new_note      out  1               one-cycle pulse: note/duration outputs hold a new note
//   note          out  NOTE_W          registered note code
//   duration      out  DUR_W           registered duration
//   song_done     out  1               level; high from song end until reset_player or reset
// BEHAVIOUR
//   Reset (reset_n=0, async):
//     - State IDLE; idx=0; new_note=0; note=0; duration=0; song_done=0.
//   States:
//     - IDLE:     play=1 -> WAIT_ROM, load wait counter with ROM_LAT.
//     - WAIT_ROM: count down while play=1, frozen while play=0; count reaching 0 -> ISSUE.
//     - ISSUE:    play=0 -> stall, no pulse.
//                 play=1 and rom_dur==0 -> DONE.
//                 Otherwise register note<=rom_note and duration<=rom_dur, set new_note for the
//                 next cycle only, -> WAIT_NOTE.
//     - WAIT_NOTE: note_done=1 (honoured regardless of play):
//                 idx==2**IDX_W-1 -> DONE; otherwise idx++ and -> WAIT_ROM (reload ROM_LAT).
//     - DONE:     song_done=1; hold until reset_player. note_done and play are ignored.
//   Latency:
//     - IDLE with play=1 sampled in cycle 0 -> new_note high in cycle ROM_LAT+2.
//     - note_done in cycle n -> next new_note in cycle n+ROM_LAT+2.
//   reset_player:
//     - Highest synchronous priority, accepted in any state.
//     - Next cycle: IDLE, idx=0, song_done=0, new_note=0. note/duration keep their last values.
//     - A note_done in the same cycle is dropped.
//   Other boundary rules:
//     - Song change without reset_player: rom_addr follows immediately; idx is not cleared.
//     - Only the last note, or an end marker, raises song_done. idx never wraps to 0.
//     - A note_done pulse outside WAIT_NOTE is ignored.
//     - new_note is never high for two consecutive cycles.
// STRUCTURE
//   Shared package song_pkg:
//     - SONG_W, IDX_W, NOTE_W and DUR_W defaults.
//     - State encodings S_IDLE, S_WAIT_ROM, S_ISSUE, S_WAIT_NOTE, S_DONE.
//     - END_MARKER_DUR = 0.
//   One sub-module, note_index_counter:
//     - IDX_W up-counter with synchronous clear and enable, plus a terminal-count flag.
//     - Asynchronous active-low reset.
//   The rest is a single FSM plus output registers and the ROM wait counter.
// TESTING
//   1 ROM_LAT=1, song=2, play=1 from cycle 0 -> rom_addr=7'h40; new_note in cycle 3 with note/dur = ROM[0x40].
//   2 Pulse note_done 10 cycles after each new_note for all 32 entries -> 32 new_note pulses, then song_done=1 held.
//   3 ROM[{1,3}].dur=0, song=1 -> 3 notes issued, then song_done=1 with no 4th new_note.
//   4 play=0 during WAIT_ROM and ISSUE for 20 cycles -> no new_note; play=1 -> pulse after remaining latency.
//   5 reset_player at the same cycle as note_done with idx=5 -> idx=0, song_done=0, IDLE; note_done dropped.
//   6 reset_n low mid-WAIT_NOTE (async, between edges) -> all outputs zero immediately; ROM_LAT=2 rerun of 1 gives new_note in cycle 4.

Source files
------------

// File: rtl/song_pkg.sv
// Shared widths, FSM state encodings and the ROM end-of-song marker for the song sequencer.
package song_pkg;

    localparam int SONG_W = 2;
    localparam int IDX_W  = 5;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;

    localparam int END_MARKER_DUR = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ROM,
        S_ISSUE,
        S_WAIT_NOTE,
        S_DONE
    } state_t;

endpackage

// File: rtl/song_sequencer_if.sv
// Song ROM read bus plus the note-player handshake, seen from the sequencer (master) side.
interface song_sequencer_if
    import song_pkg::*;
#(
    parameter int SONG_W = song_pkg::SONG_W,
    parameter int IDX_W  = song_pkg::IDX_W,
    parameter int NOTE_W = song_pkg::NOTE_W,
    parameter int DUR_W  = song_pkg::DUR_W
);
    logic [SONG_W+IDX_W-1:0] rom_addr;
    logic [NOTE_W-1:0]       rom_note;
    logic [DUR_W-1:0]        rom_dur;
    logic                    new_note;
    logic [NOTE_W-1:0]       note;
    logic [DUR_W-1:0]        duration;
    logic                    note_done;

    modport master (
        output rom_addr, new_note, note, duration,
        input  rom_note, rom_dur, note_done
    );

    modport slave (
        input  rom_addr, new_note, note, duration,
        output rom_note, rom_dur, note_done
    );
endinterface

// File: rtl/song_sequencer_note_index_counter.sv
// Note index up-counter with synchronous clear/enable and a terminal-count flag.
module note_index_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         terminal
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    assign terminal = &count;

endmodule

// File: rtl/song_sequencer.sv
// Walks the selected song's note list in the song ROM and hands each note to the note player.
module song_sequencer
    import song_pkg::*;
#(
    parameter int SONG_W  = song_pkg::SONG_W,
    parameter int IDX_W   = song_pkg::IDX_W,
    parameter int NOTE_W  = song_pkg::NOTE_W,
    parameter int DUR_W   = song_pkg::DUR_W,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              play,
    input  logic              reset_player,
    input  logic [SONG_W-1:0] song,
    output logic              song_done,
    song_sequencer_if.master  bus
);

    localparam int CNT_W = 2;

    state_t             state, state_next;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_next;
    logic [IDX_W-1:0]   idx;
    logic               idx_last;
    logic               idx_clear;
    logic               idx_en;
    logic               issue;

    note_index_counter #(.W(IDX_W)) u_idx (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (idx_clear),
        .enable   (idx_en),
        .count    (idx),
        .terminal (idx_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // reset_player overrides everything, including a coincident note_done.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        idx_clear     = 1'b0;
        idx_en        = 1'b0;
        issue         = 1'b0;
        if (reset_player) begin
            state_next    = S_IDLE;
            wait_cnt_next = '0;
            idx_clear     = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (play) begin
                        state_next    = S_WAIT_ROM;
                        wait_cnt_next = CNT_W'(ROM_LAT);
                    end
                end
                S_WAIT_ROM: begin
                    if (play) begin
                        wait_cnt_next = wait_cnt - CNT_W'(1);
                        if (wait_cnt == CNT_W'(1)) begin
                            state_next = S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (play) begin
                        if (bus.rom_dur == DUR_W'(END_MARKER_DUR)) begin
                            state_next = S_DONE;
                        end else begin
                            issue      = 1'b1;
                            state_next = S_WAIT_NOTE;
                        end
                    end
                end
                S_WAIT_NOTE: begin
                    if (bus.note_done) begin
                        if (idx_last) begin
                            state_next = S_DONE;
                        end else begin
                            idx_en        = 1'b1;
                            state_next    = S_WAIT_ROM;
                            wait_cnt_next = CNT_W'(ROM_LAT);
                        end
                    end
                end
                S_DONE: begin
                    state_next = S_DONE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.new_note <= 1'b0;
            bus.note     <= '0;
            bus.duration <= '0;
        end else begin
            bus.new_note <= issue;
            if (issue) begin
                bus.note     <= bus.rom_note;
                bus.duration <= bus.rom_dur;
            end
        end
    end

    assign bus.rom_addr = {song, idx};
    assign song_done    = (state == S_DONE);

endmodule
